// File: rtl/ma_stage.sv
// Memory-access stage: ld/st to a req/ack data bus, WB register.
// Optional: MA_MISALIGN_TRAP_EN adds misalign_exc and traps misaligned H/W.
module ma_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic        stall,
  input  logic        rst_pipe,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_adr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        ma_stall,
  output logic        bus_err,
  output logic [4:0]  rd_adr_wb,
  output logic [31:0] wbk_data_wb,
  output logic        wbk_rd_reg_wb
`ifdef MA_MISALIGN_TRAP_EN
  ,
  output logic        misalign_exc
`endif
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_a;
  logic [2:0]    r_code;
  logic          r_ld;
  logic          r_err;
  logic [31:0]   r_ld_data;

  logic          w_mem;
  logic [1:0]    w_a;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;
  logic          w_to;
  logic          w_done;
  logic [31:0]   w_wb_data;
  logic          w_wb_en;
  logic          w_mis;

  assign w_mem = cmd_ld_ma | cmd_st_ma;
  assign w_a   = rd_data_ma[1:0];

  // store lane alignment and byte enables
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = st_data_ma;
    unique case (ldst_code_ma[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_a;
        w_wdata = {4{st_data_ma[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {w_a[1], 1'b0};
        w_wdata = {2{st_data_ma[15:0]}};
      end
      default: ;
    endcase
    if (cmd_ld_ma) begin
      w_be    = 4'b1111;
      w_wdata = 32'h0;
    end
  end

  assign w_byte = dmem_rdata[{r_a, 3'b000} +: 8];
  assign w_half = r_a[1] ? dmem_rdata[31:16]
                         : dmem_rdata[15:0];

  // load lane extraction and extension
  always_comb begin
    w_ext = dmem_rdata;
    unique case (r_code)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = dmem_rdata;
    endcase
  end

  assign w_to = (ACK_TIMEOUT != 0) && !dmem_ack &&
                (r_cnt == CW'(ACK_TIMEOUT - 1));

`ifdef MA_MISALIGN_TRAP_EN
  assign w_mis = (ldst_code_ma[1:0] == 2'b01) ? w_a[0] :
                 (ldst_code_ma[1:0] != 2'b00) ? |w_a  :
                 1'b0;
`else
  assign w_mis = 1'b0;
`endif

  assign ma_stall = !rst &&
    ((r_state == IDLE && w_mem && !rst_pipe) ||
     r_state == BUSY || r_state == ABORT);

  // memory transaction FSM with registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_a        <= 2'b00;
      r_code     <= 3'b000;
      r_ld       <= 1'b0;
      r_err      <= 1'b0;
      r_ld_data  <= 32'h0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_adr   <= 30'h0;
      dmem_wdata <= 32'h0;
      dmem_be    <= 4'h0;
      bus_err    <= 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
      misalign_exc <= 1'b0;
`endif
    end else begin
      bus_err <= 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
      misalign_exc <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_mem && !rst_pipe) begin
            r_a    <= w_a;
            r_code <= ldst_code_ma;
            r_ld   <= cmd_ld_ma;
            r_cnt  <= '0;
            if (w_mis) begin
              r_state   <= DONE;
              r_err     <= 1'b1;
              r_ld_data <= 32'h0;
              dmem_we   <= cmd_st_ma;
`ifdef MA_MISALIGN_TRAP_EN
              misalign_exc <= 1'b1;
`endif
            end else begin
              r_state    <= BUSY;
              r_err      <= 1'b0;
              dmem_req   <= 1'b1;
              dmem_we    <= cmd_st_ma;
              dmem_adr   <= rd_data_ma[31:2];
              dmem_be    <= w_be;
              dmem_wdata <= w_wdata;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            r_ld_data <= w_ext;
            r_state   <= rst_pipe ? IDLE : DONE;
          end else if (w_to) begin
            dmem_req  <= 1'b0;
            bus_err   <= 1'b1;
            r_err     <= 1'b1;
            r_ld_data <= 32'h0;
            r_state   <= rst_pipe ? IDLE : DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (rst_pipe) r_state <= ABORT;
          end
        end
        ABORT: begin
          if (dmem_ack || w_to) begin
            dmem_req <= 1'b0;
            bus_err  <= w_to;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (rst_pipe || !stall) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_done    = (r_state == DONE);
  assign w_wb_data = (w_done && r_ld) ? r_ld_data
                                      : rd_data_ma;
  assign w_wb_en   = wbk_rd_reg_ma && !cmd_st_ma &&
                     !(w_done && (r_err || dmem_we));

  // write-back pipeline register
  always_ff @(posedge clk) begin
    if (rst || rst_pipe) begin
      rd_adr_wb     <= 5'h0;
      wbk_data_wb   <= 32'h0;
      wbk_rd_reg_wb <= 1'b0;
    end else if (!stall && !ma_stall) begin
      rd_adr_wb     <= rd_adr_ma;
      wbk_data_wb   <= w_wb_data;
      wbk_rd_reg_wb <= w_wb_en;
    end
  end

endmodule

// File: tb/tb_ma_stage.sv
// Directed bench for ma_stage with a write-back scoreboard.
// Build with MA_MISALIGN_TRAP_EN to cover the misalign trap.
module tb_ma_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_ld_ma, cmd_st_ma;
  logic [4:0]  rd_adr_ma;
  logic [31:0] rd_data_ma, st_data_ma;
  logic [2:0]  ldst_code_ma;
  logic        wbk_rd_reg_ma, stall, rst_pipe;
  logic        dmem_req, dmem_we;
  logic [29:0] dmem_adr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        ma_stall, bus_err;
  logic [4:0]  rd_adr_wb;
  logic [31:0] wbk_data_wb;
  logic        wbk_rd_reg_wb;
`ifdef MA_MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
    logic        en;
  } wb_t;

  wb_t q[$];
  int  n_tot  = 0;
  int  n_pass = 0;

  always #5 clk = ~clk;

  ma_stage #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma),
    .rd_adr_ma(rd_adr_ma), .rd_data_ma(rd_data_ma),
    .st_data_ma(st_data_ma),
    .ldst_code_ma(ldst_code_ma),
    .wbk_rd_reg_ma(wbk_rd_reg_ma),
    .stall(stall), .rst_pipe(rst_pipe),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_adr(dmem_adr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .ma_stall(ma_stall), .bus_err(bus_err),
    .rd_adr_wb(rd_adr_wb), .wbk_data_wb(wbk_data_wb),
    .wbk_rd_reg_wb(wbk_rd_reg_wb)
`ifdef MA_MISALIGN_TRAP_EN
    ,
    .misalign_exc(misalign_exc)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
  endtask

  task automatic wb_check(input string tag);
    wb_t e;
    chk({tag, "_sb"}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_rd"}, 32'(rd_adr_wb), 32'(e.rd));
      chk({tag, "_data"}, wbk_data_wb, e.d);
      chk({tag, "_en"}, 32'(wbk_rd_reg_wb), 32'(e.en));
    end
  endtask

  task automatic idle_in;
    cmd_ld_ma     = 1'b0;
    cmd_st_ma     = 1'b0;
    rd_adr_ma     = 5'h0;
    rd_data_ma    = 32'h0;
    st_data_ma    = 32'h0;
    ldst_code_ma  = 3'b000;
    wbk_rd_reg_ma = 1'b0;
  endtask

  task automatic set_op(input logic ld, input logic st,
                        input logic [31:0] adr,
                        input logic [2:0] code,
                        input logic [31:0] sd,
                        input logic [4:0] rd);
    cmd_ld_ma     = ld;
    cmd_st_ma     = st;
    rd_data_ma    = adr;
    ldst_code_ma  = code;
    st_data_ma    = sd;
    rd_adr_ma     = rd;
    wbk_rd_reg_ma = 1'b1;
  endtask

  // one ld/st with ack in the first BUSY cycle
  task automatic do_mem(input string tag,
                        input logic ld, input logic st,
                        input logic [31:0] adr,
                        input logic [2:0] code,
                        input logic [31:0] sd,
                        input logic [31:0] rdat,
                        input logic [3:0] ebe,
                        input logic [31:0] ewd,
                        input logic [31:0] ewb,
                        input logic [4:0] rd);
    wb_t e;
    set_op(ld, st, adr, code, sd, rd);
    e.rd = rd;
    e.d  = ld ? ewb : adr;
    e.en = ld;
    q.push_back(e);
    #1;
    chk({tag, "_stall_idle"}, 32'(ma_stall), 32'd1);
    chk({tag, "_req_idle"}, 32'(dmem_req), 32'd0);
    tick;
    chk({tag, "_req"}, 32'(dmem_req), 32'd1);
    chk({tag, "_we"}, 32'(dmem_we), 32'(st));
    chk({tag, "_adr"}, 32'(dmem_adr), 32'(adr[31:2]));
    chk({tag, "_be"}, 32'(dmem_be), 32'(ebe));
    if (st) chk({tag, "_wdata"}, dmem_wdata, ewd);
    chk({tag, "_stall_busy"}, 32'(ma_stall), 32'd1);
    dmem_ack   = 1'b1;
    dmem_rdata = rdat;
    tick;
    dmem_ack = 1'b0;
    chk({tag, "_stall_done"}, 32'(ma_stall), 32'd0);
    chk({tag, "_req_done"}, 32'(dmem_req), 32'd0);
    tick;
    wb_check(tag);
    idle_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_t e;
    rst        = 1'b1;
    stall      = 1'b0;
    rst_pipe   = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    idle_in();
    tick;
    tick;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(ma_stall), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_berr", 32'(bus_err), 32'd0);
    chk("rst_wbd", wbk_data_wb, 32'd0);
    chk("rst_wben", 32'(wbk_rd_reg_wb), 32'd0);
    rst = 1'b0;
    tick;

    do_mem("lb", 1, 0, 32'h1003, 3'b000, 0,
           32'h80FF_0000, 4'b1111, 0, 32'hFFFF_FF80, 5);
    do_mem("sh", 0, 1, 32'h2002, 3'b001, 32'h1234_ABCD,
           0, 4'b1100, 32'hABCD_ABCD, 0, 7);

    set_op(1, 0, 32'h12, 3'b101, 0, 9);
    e.rd = 9; e.d = 32'h0000_BEEF; e.en = 1;
    q.push_back(e);
    tick;
    for (int i = 0; i < 6; i++) begin
      chk("lhu_req", 32'(dmem_req), 32'd1);
      chk("lhu_adr", 32'(dmem_adr), 32'h4);
      chk("lhu_stall", 32'(ma_stall), 32'd1);
      if (i == 5) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBEEF_1234;
      end
      tick;
    end
    dmem_ack = 1'b0;
    stall    = 1'b1;
    #1;
    chk("lhu_done_stall", 32'(ma_stall), 32'd0);
    chk("lhu_done_req", 32'(dmem_req), 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1111_1111;
    tick;
    dmem_ack = 1'b0;
    chk("lhu_hold", wbk_data_wb, 32'h2002);
    tick;
    chk("lhu_hold2", 32'(rd_adr_wb), 32'd7);
    stall = 1'b0;
    tick;
    wb_check("lhu");
    idle_in();

    set_op(1, 0, 32'h40, 3'b010, 0, 3);
    e.rd = 3; e.d = 32'h0; e.en = 0;
    q.push_back(e);
    tick;
    for (int i = 0; i < 16; i++) begin
      chk("to_req", 32'(dmem_req), 32'd1);
      chk("to_berr_lo", 32'(bus_err), 32'd0);
      tick;
    end
    chk("to_berr_hi", 32'(bus_err), 32'd1);
    chk("to_req_drop", 32'(dmem_req), 32'd0);
    chk("to_stall", 32'(ma_stall), 32'd0);
    tick;
    chk("to_berr_end", 32'(bus_err), 32'd0);
    wb_check("to");
    idle_in();

    set_op(1, 0, 32'h80, 3'b010, 0, 4);
    tick;
    chk("ab_busy1", 32'(dmem_req), 32'd1);
    tick;
    rst_pipe = 1'b1;
    tick;
    rst_pipe = 1'b0;
    idle_in();
    #1;
    chk("ab_stall", 32'(ma_stall), 32'd1);
    chk("ab_req", 32'(dmem_req), 32'd1);
    chk("ab_wb_rd", 32'(rd_adr_wb), 32'd0);
    chk("ab_wb_d", wbk_data_wb, 32'd0);
    tick;
    chk("ab_req2", 32'(dmem_req), 32'd1);
    tick;
    chk("ab_req3", 32'(dmem_req), 32'd1);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    tick;
    dmem_ack = 1'b0;
    chk("ab_req_drop", 32'(dmem_req), 32'd0);
    chk("ab_idle", 32'(ma_stall), 32'd0);
    tick;
    chk("ab_wb_d2", wbk_data_wb, 32'd0);
    chk("ab_wb_en", 32'(wbk_rd_reg_wb), 32'd0);

    rd_adr_ma     = 10;
    rd_data_ma    = 32'h55;
    wbk_rd_reg_ma = 1'b1;
    e.rd = 10; e.d = 32'h55; e.en = 1;
    q.push_back(e);
    #1;
    chk("add_stall", 32'(ma_stall), 32'd0);
    tick;
    wb_check("add");
    idle_in();
    do_mem("lw", 1, 0, 32'h100, 3'b010, 0,
           32'hCAFE_F00D, 4'b1111, 0, 32'hCAFE_F00D, 11);
    do_mem("sb", 0, 1, 32'h5, 3'b000, 32'h0000_00AB,
           0, 4'b0010, 32'hABAB_ABAB, 0, 12);
    do_mem("lbu", 1, 0, 32'h2, 3'b100, 0,
           32'h00F0_0000, 4'b1111, 0, 32'h0000_00F0, 13);
    do_mem("lh", 1, 0, 32'h0, 3'b001, 0,
           32'h0000_8001, 4'b1111, 0, 32'hFFFF_8001, 14);
    do_mem("sw", 0, 1, 32'h13, 3'b010, 32'h0BAD_F00D,
           0, 4'b1111, 32'h0BAD_F00D, 0, 15);

`ifdef MA_MISALIGN_TRAP_EN
    set_op(1, 0, 32'h1001, 3'b010, 0, 16);
    e.rd = 16; e.d = 32'h0; e.en = 0;
    q.push_back(e);
    tick;
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_exc", 32'(misalign_exc), 32'd1);
    chk("mis_stall", 32'(ma_stall), 32'd0);
    tick;
    chk("mis_exc_end", 32'(misalign_exc), 32'd0);
    wb_check("mis");
    idle_in();
`endif

    tick;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ma_stage.md
Name: ma_stage

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and consumes its MA-side pipeline registers.
- Turns load/store commands into a req/ack data-memory transaction, with byte-lane alignment, byte enables and load sign/zero extension. Stalls the pipeline while a transaction is outstanding.
- Registers the write-back data, destination and enable into the WB-side pipeline register.
- Non-memory instructions pass through in one cycle.

Parameters:
- ACK_TIMEOUT, 16: number of BUSY cycles without dmem_ack before a bus error is declared; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_ld_ma  in  1  load command in MA
- cmd_st_ma  in  1  store command in MA
- rd_adr_ma  in  5  destination register
- rd_data_ma  in  32  ALU result; byte address for ld/st
- st_data_ma  in  32  store data, unaligned (LSB-justified)
- ldst_code_ma  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- wbk_rd_reg_ma  in  1  write-back enable
- stall  in  1  external pipeline stall
- rst_pipe  in  1  pipeline flush
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write
- dmem_adr  out  30  word address [31:2]
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  transaction complete; rdata valid on ack for reads
- dmem_rdata  in  32  read data
- ma_stall  out  1  this stage needs the pipeline held
- bus_err  out  1  one-cycle pulse on timeout
- rd_adr_wb  out  5  WB destination
- wbk_data_wb  out  32  WB data
- wbk_rd_reg_wb  out  1  WB enable

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; timeout counter goes to 0. rst is synchronous and has priority over rst_pipe.
- FSM states: IDLE, BUSY, DONE, ABORT.
- IDLE with (cmd_ld_ma | cmd_st_ma):
  - ma_stall=1 combinationally.
  - Next cycle enter BUSY with dmem_adr/we/be/wdata registered from the inputs.
- BUSY:
  - dmem_req=1, ma_stall=1.
  - Request signals are stable until the ack cycle.
  - On dmem_ack: capture the aligned load result, drop req next cycle, go to DONE.
- DONE:
  - ma_stall=0. The WB register loads when ~stall; the state then returns to IDLE.
  - If stall=1, remain in DONE and hold the captured data.
  - Minimum memory-op occupancy is 3 cycles when ack arrives in the first BUSY cycle.
- Non-memory op in IDLE: ma_stall=0; the WB register loads when ~stall.
- WB register:
  - Hold whenever stall | ma_stall.
  - wbk_data_wb = load result for loads, rd_data_ma otherwise.
  - Stores force wbk_rd_reg_wb=0.
- Store alignment, a = rd_data_ma[1:0]:
  - SB: be = 0001 << a; wdata = byte replicated x4.
  - SH: be = 0011 << {a[1],1'b0}; wdata = halfword replicated x2.
  - SW: be = 1111.
- Load extraction:
  - Select byte lane a or halfword lane a[1].
  - Sign-extend for 000/001; zero-extend for 100/101; word for 010.
  - Loads drive dmem_be=1111.
- Misaligned accesses: low address bits beyond the access size are ignored. H uses a[1]; W ignores a.
- Timeout (ACK_TIMEOUT>0):
  - Counter increments each BUSY cycle without ack.
  - When it reaches ACK_TIMEOUT-1 without ack: req drops, bus_err pulses one cycle, state goes to DONE with load data 0 and wbk_rd_reg forced to 0 for that instruction.
- rst_pipe:
  - Clears the WB register to 0.
  - IDLE/DONE go to IDLE.
  - BUSY goes to ABORT: req stays high until ack (or timeout), the response is discarded, then IDLE.
  - ma_stall=1 in ABORT.
  - A new ld/st in IDLE is not accepted on a rst_pipe cycle.
- Ack while not in BUSY/ABORT is ignored.

Optional Feature:
- Macro: MA_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign_exc (1 bit, reset 0).
  - A halfword with a[0]=1 or a word with a!=0 issues no memory request.
  - The FSM goes IDLE->DONE directly with a one-cycle misalign_exc pulse; wbk_rd_reg_wb=0 for that instruction.
- When not defined: the port is absent and misaligned accesses are truncated as described in Behaviour.

Test Plan:
- LB adr 0x0000_1003, rdata 0x80FF_0000, ack in first BUSY cycle -> ma_stall high 2 cycles; wbk_data_wb=0xFFFF_FF80 in DONE+1.
- SH adr 0x0000_2002, st_data 0x1234_ABCD -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, wbk_rd_reg_wb=0.
- LHU adr 0x12, ack delayed 5 cycles with stall pulsed high during DONE -> req held steady 6 BUSY cycles; DONE held until stall falls; wbk_data_wb=zero-extended upper half.
- Load, no ack, ACK_TIMEOUT=16 -> bus_err single pulse after 16 BUSY cycles; wbk_rd_reg_wb=0.
- rst_pipe asserted in 2nd BUSY cycle, ack 3 cycles later with rdata 0xDEADBEEF -> ABORT; req held until ack; WB register stays 0; IDLE next.
- Back-to-back ADD (rd_data 0x55) then LW -> ADD written back after 1 cycle with data 0x55; LW stalls normally; with MA_MISALIGN_TRAP_EN, LW adr 0x1001 -> no dmem_req, misalign_exc one pulse.
